mem_access_stage: RTL and testbench
===================================

Name: mem_access_stage

Overview:
- MEM pipeline stage of the MIPS core; consumes the memory and write-back control buses produced in decode and carried through EX/MEM.
- Drives the synchronous data BRAM:
  - byte-enable generation for SB/SH/SW;
  - extraction and sign/zero extension for LB/LH/LW/LBU/LHU.
- Resolves BEQ/BNE.
- Owns the MEM/WB pipeline register.

Parameters:
- len_mem_bus, 9, memory control bus width.
- len_wb_bus, 2, write-back control bus width.
- len_data, 32, data word width.
- len_addr, 10, BRAM word-address width.
- len_reg, 5, register index width.

Ports:
- clk  in  1  clock, rising edge.
- reset  in  1  synchronous, active-high.
- enable  in  1  pipeline advance (debug step); 0 holds stage.
- memory_bus  in  len_mem_bus  [8] BNE, [7] SB, [6] SH, [5] LB, [4] LH, [3] Unsigned, [2] Branch, [1] MemRead, [0] MemWrite.
- writeBack_bus_in  in  len_wb_bus  [1] RegWrite, [0] MemtoReg.
- alu_result  in  len_data  byte address / ALU result.
- alu_zero  in  1  ALU zero flag.
- store_data  in  len_data  rt value for stores.
- rd_in  in  len_reg  destination register.
- branch_target  in  len_data  computed branch PC.
- mem_rdata  in  len_data  BRAM read word, valid one cycle after mem_en.
- mem_en  out  1  BRAM enable.
- mem_we  out  4  byte write enables, little-endian lanes.
- mem_addr  out  len_addr  alu_result[len_addr+1:2].
- mem_wdata  out  len_data  lane-replicated store data.
- pc_src  out  1  branch taken.
- pc_branch  out  len_data  branch_target passthrough.
- writeBack_bus_out  out  len_wb_bus  registered WB control.
- read_data  out  len_data  extended load result.
- alu_result_out  out  len_data  registered ALU result.
- rd_out  out  len_reg  registered destination register.
- misaligned  out  1  sticky alignment error.

Behaviour:
- Combinational outputs; all are 0 while reset=1.
  - mem_en = enable & (MemRead | MemWrite).
  - pc_src = enable & Branch & (alu_zero XOR BNE).
- Store byte enables and write data:
  - SB: mem_we = 1 << addr[1:0]; mem_wdata = {4{store_data[7:0]}}.
  - SH: mem_we = addr[1] ? 1100 : 0011; mem_wdata = {2{store_data[15:0]}}.
  - SW: mem_we = 1111; mem_wdata = store_data.
- Alignment:
  - Misaligned cases: SH/LH with addr[0]=1; SW/LW with addr[1:0]≠0.
  - Misaligned store: mem_we=0000.
  - Misaligned load: RegWrite cleared in the MEM/WB register.
  - Either case sets misaligned on the next edge. misaligned stays set until reset.
- mem_we is 0000 whenever MemWrite=0 or enable=0.
- MEM/WB register: on posedge with enable=1, capture:
  - writeBack_bus_in, with RegWrite masked as above;
  - alu_result, rd_in;
  - addr[1:0] and the LB/LH/Unsigned flags.
- enable=0: MEM/WB register holds and mem_en=0, so the BRAM output holds.
- Load latency: 1 cycle. read_data is combinational from mem_rdata and the registered offset/flags:
  - byte = mem_rdata[8*off +: 8];
  - half = off[1] ? [31:16] : [15:0];
  - sign-extended unless Unsigned is set; word otherwise.
  - Non-load entries present read_data = mem_rdata unmodified (ignored when MemtoReg=0).
- Reset: all registered outputs clear to 0, including misaligned and the captured flags. Reset asserted mid-load discards the load; the WB bus after reset is 00.
- Simultaneous Branch and MemWrite bits: both honoured independently. Unknown bus codes decode as no access.

Test Plan:
- Store/load round trip: SW store_data=0x8081F2F3 at addr 0x10, then LB addr 0x11 -> read_data=0xFFFFFFF2 one cycle later; LBU addr 0x13 -> 0x00000080.
- SH addr 0x22 with store_data=0x0000ABCD -> mem_we=1100, mem_wdata=0xABCDABCD; following LH addr 0x22 -> 0xFFFFABCD; LHU -> 0x0000ABCD.
- Misaligned: SW at addr 0x05 -> mem_we=0000, misaligned=1 next cycle, and it stays 1 through later valid accesses until reset.
- Branch: Branch=1, BNE=0, alu_zero=1 -> pc_src=1, pc_branch=branch_target. With BNE=1 and alu_zero=1 -> pc_src=0. With BNE=1 and alu_zero=0 -> pc_src=1.
- Stall: hold enable=0 for 3 cycles during LW -> mem_en=0, mem_we=0, WB outputs and read_data unchanged; resume -> pipeline continues with no lost or duplicated capture.
- Reset during outstanding LB -> next cycle writeBack_bus_out=00, read_data/alu_result_out/rd_out=0, misaligned=0.

Source files
------------

// File: rtl/mem_access_stage.sv
// mem_access_stage
// ----------------
// MEM stage of the MIPS pipeline. It turns the decoded memory control bus into
// accesses on a synchronous data BRAM, resolves BEQ/BNE, and holds the MEM/WB
// pipeline register that feeds write-back.
//
// Store handling covers SB/SH/SW: it generates the byte-lane write enables and
// replicates the store data across the lanes. Load handling covers
// LB/LH/LW/LBU/LHU: it picks the addressed byte or half out of the word the BRAM
// returns one cycle later, then sign- or zero-extends it.
//
// Ports
//   clk, reset          rising-edge clock, synchronous active-high reset
//   enable              pipeline advance; 0 freezes the stage and the BRAM
//   memory_bus          [8] BNE [7] SB [6] SH [5] LB [4] LH [3] Unsigned
//                       [2] Branch [1] MemRead [0] MemWrite
//   writeBack_bus_in    [1] RegWrite [0] MemtoReg
//   alu_result          byte address or ALU result
//   alu_zero            ALU zero flag used for branch resolution
//   store_data          rt value for stores
//   rd_in               destination register index
//   branch_target       computed branch PC
//   mem_rdata           BRAM read word, valid one cycle after mem_en
//   mem_en/mem_we       BRAM enable and little-endian byte write enables
//   mem_addr/mem_wdata  BRAM word address and lane-replicated write data
//   pc_src/pc_branch    branch taken flag and branch PC
//   writeBack_bus_out   registered write-back control
//   read_data           extended load result
//   alu_result_out      registered ALU result
//   rd_out              registered destination register
//   misaligned          sticky alignment error, cleared only by reset
module mem_access_stage #(
  parameter int len_mem_bus = 9,
  parameter int len_wb_bus  = 2,
  parameter int len_data    = 32,
  parameter int len_addr    = 10,
  parameter int len_reg     = 5
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   enable,
  input  logic [len_mem_bus-1:0] memory_bus,
  input  logic [len_wb_bus-1:0]  writeBack_bus_in,
  input  logic [len_data-1:0]    alu_result,
  input  logic                   alu_zero,
  input  logic [len_data-1:0]    store_data,
  input  logic [len_reg-1:0]     rd_in,
  input  logic [len_data-1:0]    branch_target,
  input  logic [len_data-1:0]    mem_rdata,
  output logic                   mem_en,
  output logic [3:0]             mem_we,
  output logic [len_addr-1:0]    mem_addr,
  output logic [len_data-1:0]    mem_wdata,
  output logic                   pc_src,
  output logic [len_data-1:0]    pc_branch,
  output logic [len_wb_bus-1:0]  writeBack_bus_out,
  output logic [len_data-1:0]    read_data,
  output logic [len_data-1:0]    alu_result_out,
  output logic [len_reg-1:0]     rd_out,
  output logic                   misaligned
);

  logic busBne, busSb, busSh, busLb, busLh, busUns, busBranch, busRead, busWrite;
  logic [1:0] byteOff;
  logic stageActive;
  logic storeOp, loadOp;
  logic storeByte, storeHalf, storeWord;
  logic loadByte, loadHalf, loadWord;
  logic storeMis, loadMis;
  logic [3:0] laneMask;
  logic [len_data-1:0] laneData;

  logic [len_wb_bus-1:0] wbQ, wbD;
  logic [len_data-1:0]   aluQ, aluD;
  logic [len_reg-1:0]    rdQ, rdD;
  logic [1:0]            offQ, offD;
  logic                  lbQ, lbD, lhQ, lhD, unsQ, unsD;
  logic                  validQ, validD;
  logic                  misQ, misD;

  logic [7:0]  byteLane;
  logic [15:0] halfLane;

  assign busBne    = memory_bus[8];
  assign busSb     = memory_bus[7];
  assign busSh     = memory_bus[6];
  assign busLb     = memory_bus[5];
  assign busLh     = memory_bus[4];
  assign busUns    = memory_bus[3];
  assign busBranch = memory_bus[2];
  assign busRead   = memory_bus[1];
  assign busWrite  = memory_bus[0];

  assign byteOff     = alu_result[1:0];
  assign stageActive = enable & ~reset;

  // Contradictory codes (read and write together, or both size bits set)
  // decode as no access, so they never write or capture load flags.
  assign storeOp = busWrite & ~busRead & ~(busSb & busSh);
  assign loadOp  = busRead & ~busWrite & ~(busLb & busLh);

  assign storeByte = storeOp & busSb;
  assign storeHalf = storeOp & busSh;
  assign storeWord = storeOp & ~busSb & ~busSh;
  assign loadByte  = loadOp & busLb;
  assign loadHalf  = loadOp & busLh;
  assign loadWord  = loadOp & ~busLb & ~busLh;

  assign storeMis = (storeHalf & byteOff[0]) | (storeWord & (byteOff != 2'b00));
  assign loadMis  = (loadHalf & byteOff[0]) | (loadWord & (byteOff != 2'b00));

  // Lane enables and replicated data, so the BRAM only has to honour mem_we.
  always_comb begin
    laneMask = 4'b0000;
    laneData = store_data;
    if (storeByte) begin
      laneMask = 4'b0001 << byteOff;
      laneData = {4{store_data[7:0]}};
    end else if (storeHalf) begin
      laneMask = byteOff[1] ? 4'b1100 : 4'b0011;
      laneData = {2{store_data[15:0]}};
    end else if (storeWord) begin
      laneMask = 4'b1111;
    end
  end

  assign mem_en    = stageActive & (busRead | busWrite);
  assign pc_src    = stageActive & busBranch & (alu_zero ^ busBne);
  assign mem_we    = (stageActive & ~storeMis) ? laneMask : 4'b0000;
  assign mem_addr  = reset ? '0 : alu_result[len_addr+1:2];
  assign mem_wdata = reset ? '0 : laneData;
  assign pc_branch = reset ? '0 : branch_target;

  // MEM/WB next state. A misaligned load keeps travelling down the pipe, but it
  // loses RegWrite so that it cannot corrupt the register file.
  always_comb begin
    wbD    = wbQ;
    aluD   = aluQ;
    rdD    = rdQ;
    offD   = offQ;
    lbD    = lbQ;
    lhD    = lhQ;
    unsD   = unsQ;
    validD = validQ;
    misD   = misQ;
    if (enable) begin
      wbD    = writeBack_bus_in;
      wbD[1] = writeBack_bus_in[1] & ~loadMis;
      aluD   = alu_result;
      rdD    = rd_in;
      offD   = byteOff;
      lbD    = loadByte;
      lhD    = loadHalf;
      unsD   = busUns;
      validD = 1'b1;
      misD   = misQ | storeMis | loadMis;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      wbQ    <= '0;
      aluQ   <= '0;
      rdQ    <= '0;
      offQ   <= '0;
      lbQ    <= 1'b0;
      lhQ    <= 1'b0;
      unsQ   <= 1'b0;
      validQ <= 1'b0;
      misQ   <= 1'b0;
    end else begin
      wbQ    <= wbD;
      aluQ   <= aluD;
      rdQ    <= rdD;
      offQ   <= offD;
      lbQ    <= lbD;
      lhQ    <= lhD;
      unsQ   <= unsD;
      validQ <= validD;
      misQ   <= misD;
    end
  end

  assign writeBack_bus_out = wbQ;
  assign alu_result_out    = aluQ;
  assign rd_out            = rdQ;
  assign misaligned        = misQ;

  // The BRAM output is not reset. validQ hides whatever word it still holds
  // until the first capture after reset.
  always_comb begin
    byteLane = mem_rdata[{offQ, 3'b000} +: 8];
    halfLane = offQ[1] ? mem_rdata[31:16] : mem_rdata[15:0];
    if (reset || !validQ) begin
      read_data = '0;
    end else if (lbQ) begin
      read_data = unsQ ? {{(len_data-8){1'b0}}, byteLane}
                       : {{(len_data-8){byteLane[7]}}, byteLane};
    end else if (lhQ) begin
      read_data = unsQ ? {{(len_data-16){1'b0}}, halfLane}
                       : {{(len_data-16){halfLane[15]}}, halfLane};
    end else begin
      read_data = mem_rdata;
    end
  end

endmodule

// File: tb/tb_mem_access_stage.sv
// tb_mem_access_stage
// -------------------
// Drives mem_access_stage with directed instruction vectors against a small
// synchronous read-first BRAM. It keeps a byte-addressed reference model of
// memory and of the MEM/WB contents, which the negedge compare process checks
// every cycle, alongside hand-computed literal expectations.
module tb_mem_access_stage;

  localparam logic [8:0] B_WR = 9'h001;
  localparam logic [8:0] B_RD = 9'h002;
  localparam logic [8:0] B_BR = 9'h004;
  localparam logic [8:0] B_UN = 9'h008;
  localparam logic [8:0] B_LH = 9'h010;
  localparam logic [8:0] B_LB = 9'h020;
  localparam logic [8:0] B_SH = 9'h040;
  localparam logic [8:0] B_SB = 9'h080;
  localparam logic [8:0] B_NE = 9'h100;

  logic        clk = 1'b0;
  logic        reset;
  logic        enable;
  logic [8:0]  memory_bus;
  logic [1:0]  writeBack_bus_in;
  logic [31:0] alu_result;
  logic        alu_zero;
  logic [31:0] store_data;
  logic [4:0]  rd_in;
  logic [31:0] branch_target;
  logic [31:0] mem_rdata = '0;
  logic        mem_en;
  logic [3:0]  mem_we;
  logic [9:0]  mem_addr;
  logic [31:0] mem_wdata;
  logic        pc_src;
  logic [31:0] pc_branch;
  logic [1:0]  writeBack_bus_out;
  logic [31:0] read_data;
  logic [31:0] alu_result_out;
  logic [4:0]  rd_out;
  logic        misaligned;

  int   nVectors = 0;
  int   nMiss = 0;
  logic checkEn = 1'b0;

  logic [31:0] bram [1024] = '{default: 32'h0};
  logic [7:0]  mMem [4096] = '{default: 8'h0};
  logic        mValid = 1'b0;
  logic [1:0]  mWb = '0;
  logic [31:0] mAlu = '0;
  logic [4:0]  mRd = '0;
  logic        mMis = 1'b0;
  logic [31:0] mExpRead = '0;
  logic [31:0] mRdata = '0;

  mem_access_stage dut (
    .clk(clk),
    .reset(reset),
    .enable(enable),
    .memory_bus(memory_bus),
    .writeBack_bus_in(writeBack_bus_in),
    .alu_result(alu_result),
    .alu_zero(alu_zero),
    .store_data(store_data),
    .rd_in(rd_in),
    .branch_target(branch_target),
    .mem_rdata(mem_rdata),
    .mem_en(mem_en),
    .mem_we(mem_we),
    .mem_addr(mem_addr),
    .mem_wdata(mem_wdata),
    .pc_src(pc_src),
    .pc_branch(pc_branch),
    .writeBack_bus_out(writeBack_bus_out),
    .read_data(read_data),
    .alu_result_out(alu_result_out),
    .rd_out(rd_out),
    .misaligned(misaligned)
  );

  always #5 clk = ~clk;

  // Read-first synchronous BRAM with byte-lane writes.
  always @(posedge clk) begin
    if (mem_en) begin
      mem_rdata <= bram[mem_addr];
      for (int i = 0; i < 4; i++)
        if (mem_we[i]) bram[mem_addr][8*i +: 8] <= mem_wdata[8*i +: 8];
    end
  end

  function automatic int storeSize(input logic [8:0] bus);
    if (!bus[0] || bus[1]) return 0;
    if (bus[7] && bus[6]) return 0;
    if (bus[7]) return 1;
    if (bus[6]) return 2;
    return 4;
  endfunction

  function automatic int loadSize(input logic [8:0] bus);
    if (!bus[1] || bus[0]) return 0;
    if (bus[5] && bus[4]) return 0;
    if (bus[5]) return 1;
    if (bus[4]) return 2;
    return 4;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    nVectors++;
    if (act !== exp) begin
      nMiss++;
      $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
    end
  endtask

  // Reference model: byte memory plus the expected MEM/WB entry.
  task automatic updateModel();
    logic [11:0] a, base, hb;
    int sn, ln;
    logic stBad, ldBad;
    logic [31:0] word, val;
    logic [7:0] b;
    logic [15:0] h;
    if (reset) begin
      mValid <= 1'b0; mWb <= '0; mAlu <= '0; mRd <= '0; mMis <= 1'b0; mExpRead <= '0;
    end else if (enable) begin
      a = alu_result[11:0];
      base = {a[11:2], 2'b00};
      hb = {a[11:1], 1'b0};
      sn = storeSize(memory_bus);
      ln = loadSize(memory_bus);
      stBad = (sn != 0) && ((int'(a) % sn) != 0);
      ldBad = (ln != 0) && ((int'(a) % ln) != 0);
      word = {mMem[base+3], mMem[base+2], mMem[base+1], mMem[base]};
      val = (memory_bus[0] || memory_bus[1]) ? word : mRdata;
      if (memory_bus[0] || memory_bus[1]) mRdata <= word;
      b = mMem[a];
      h = {mMem[hb+1], mMem[hb]};
      if (ln == 1) begin
        if (memory_bus[3]) val = 32'(b);
        else val = int'($signed(b));
      end else if (ln == 2) begin
        if (memory_bus[3]) val = 32'(h);
        else val = int'($signed(h));
      end
      if (sn != 0 && !stBad)
        for (int i = 0; i < sn; i++) mMem[a+i] <= store_data[8*i +: 8];
      mMis <= mMis | stBad | ldBad;
      mWb <= {writeBack_bus_in[1] & ~ldBad, writeBack_bus_in[0]};
      mAlu <= alu_result;
      mRd <= rd_in;
      mExpRead <= val;
      mValid <= 1'b1;
    end
  endtask

  always @(posedge clk) updateModel();

  task automatic checkOutput();
    int sn;
    logic [3:0] eWe;
    logic [31:0] eWd;
    if (reset) begin
      check("rst_mem_en", mem_en, 0);
      check("rst_mem_we", mem_we, 0);
      check("rst_mem_addr", mem_addr, 0);
      check("rst_mem_wdata", mem_wdata, 0);
      check("rst_pc_src", pc_src, 0);
      check("rst_pc_branch", pc_branch, 0);
      check("rst_read_data", read_data, 0);
    end else begin
      sn = storeSize(memory_bus);
      eWe = 4'b0000;
      eWd = store_data;
      if (enable && sn != 0 && ((int'(alu_result[11:0]) % sn) == 0))
        eWe = 4'(((1 << sn) - 1) << alu_result[1:0]);
      if (sn == 1) eWd = {4{store_data[7:0]}};
      else if (sn == 2) eWd = {2{store_data[15:0]}};
      check("mem_en", mem_en, enable & (memory_bus[0] | memory_bus[1]));
      check("pc_src", pc_src, enable & memory_bus[2] & (alu_zero ^ memory_bus[8]));
      check("pc_branch", pc_branch, branch_target);
      check("mem_addr", mem_addr, alu_result[11:2]);
      check("mem_we", mem_we, eWe);
      if (eWe != 4'b0000) check("mem_wdata", mem_wdata, eWd);
      check("read_data", read_data, mValid ? mExpRead : 32'h0);
    end
    check("wb_out", writeBack_bus_out, mWb);
    check("alu_out", alu_result_out, mAlu);
    check("rd_out", rd_out, mRd);
    check("misaligned", misaligned, mMis);
  endtask

  always @(negedge clk) if (checkEn) checkOutput();

  task automatic applyStimulus(input logic [8:0] bus, input logic [1:0] wb, input logic [31:0] alu,
                               input logic zero, input logic [31:0] sdata, input logic [4:0] rd,
                               input logic en);
    memory_bus = bus;
    writeBack_bus_in = wb;
    alu_result = alu;
    alu_zero = zero;
    store_data = sdata;
    rd_in = rd;
    enable = en;
    branch_target = 32'h0040_0000 + alu;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    reset = 1'b1;
    applyStimulus(B_WR | B_BR, 2'b11, 32'h10, 1'b1, 32'hDEADBEEF, 5'd9, 1'b1);
    checkEn = 1'b1;
    #1;
    check("lit_rst_mem_en", mem_en, 0);
    check("lit_rst_pc_src", pc_src, 0);
    check("lit_rst_mem_we", mem_we, 0);
    tick();
    tick();
    check("lit_rst_wb", writeBack_bus_out, 0);
    check("lit_rst_mis", misaligned, 0);
    reset = 1'b0;

    applyStimulus(B_WR, 2'b00, 32'h10, 1'b0, 32'h8081F2F3, 5'd0, 1'b1);
    #1;
    check("lit_sw_we", mem_we, 4'hF);
    check("lit_sw_wdata", mem_wdata, 32'h8081F2F3);
    tick();
    applyStimulus(B_RD | B_LB, 2'b11, 32'h11, 1'b0, 32'h0, 5'd3, 1'b1);
    tick();
    check("lit_lb", read_data, 32'hFFFFFFF2);
    check("lit_lb_model", mExpRead, 32'hFFFFFFF2);
    check("lit_lb_wb", writeBack_bus_out, 2'b11);
    check("lit_lb_rd", rd_out, 3);
    applyStimulus(B_RD | B_LB | B_UN, 2'b11, 32'h13, 1'b0, 32'h0, 5'd4, 1'b1);
    tick();
    check("lit_lbu", read_data, 32'h00000080);

    applyStimulus(B_WR | B_SH, 2'b00, 32'h22, 1'b0, 32'h0000ABCD, 5'd0, 1'b1);
    #1;
    check("lit_sh_we", mem_we, 4'b1100);
    check("lit_sh_wdata", mem_wdata, 32'hABCDABCD);
    tick();
    applyStimulus(B_RD | B_LH, 2'b11, 32'h22, 1'b0, 32'h0, 5'd5, 1'b1);
    tick();
    check("lit_lh", read_data, 32'hFFFFABCD);
    applyStimulus(B_RD | B_LH | B_UN, 2'b11, 32'h22, 1'b0, 32'h0, 5'd6, 1'b1);
    tick();
    check("lit_lhu", read_data, 32'h0000ABCD);
    check("lit_lhu_model", mExpRead, 32'h0000ABCD);

    applyStimulus(B_WR | B_SB, 2'b00, 32'h31, 1'b0, 32'h0000005A, 5'd0, 1'b1);
    #1;
    check("lit_sb_we", mem_we, 4'b0010);
    check("lit_sb_wdata", mem_wdata, 32'h5A5A5A5A);
    tick();
    applyStimulus(B_RD, 2'b11, 32'h30, 1'b0, 32'h0, 5'd2, 1'b1);
    tick();
    check("lit_lw_sb", read_data, 32'h00005A00);

    applyStimulus(B_BR, 2'b00, 32'h100, 1'b1, 32'h0, 5'd0, 1'b1);
    #1;
    check("lit_beq_taken", pc_src, 1);
    check("lit_pc_branch", pc_branch, 32'h00400100);
    tick();
    applyStimulus(B_BR | B_NE, 2'b00, 32'h100, 1'b1, 32'h0, 5'd0, 1'b1);
    #1;
    check("lit_bne_not_taken", pc_src, 0);
    tick();
    applyStimulus(B_BR | B_NE, 2'b00, 32'h100, 1'b0, 32'h0, 5'd0, 1'b1);
    #1;
    check("lit_bne_taken", pc_src, 1);
    tick();
    applyStimulus(B_BR | B_WR, 2'b00, 32'h40, 1'b0, 32'h12345678, 5'd0, 1'b1);
    #1;
    check("lit_br_sw_pc", pc_src, 0);
    check("lit_br_sw_we", mem_we, 4'hF);
    tick();

    applyStimulus(B_RD, 2'b11, 32'h10, 1'b0, 32'h0, 5'd7, 1'b1);
    tick();
    applyStimulus(B_RD | B_LB, 2'b11, 32'h12, 1'b0, 32'h0, 5'd8, 1'b0);
    for (int k = 0; k < 3; k++) begin
      #1;
      check("lit_stall_mem_en", mem_en, 0);
      tick();
      check("lit_stall_read", read_data, 32'h8081F2F3);
      check("lit_stall_rd", rd_out, 7);
      check("lit_stall_wb", writeBack_bus_out, 2'b11);
    end
    applyStimulus(B_RD | B_LB, 2'b11, 32'h12, 1'b0, 32'h0, 5'd8, 1'b1);
    tick();
    check("lit_resume_read", read_data, 32'hFFFFFF81);
    check("lit_resume_rd", rd_out, 8);
    applyStimulus(9'h000, 2'b10, 32'h55, 1'b0, 32'h0, 5'd9, 1'b1);
    tick();
    check("lit_alu_rd", rd_out, 9);
    check("lit_alu_out", alu_result_out, 32'h55);
    check("lit_alu_raw_read", read_data, 32'h8081F2F3);

    applyStimulus(B_WR, 2'b00, 32'h05, 1'b0, 32'h11111111, 5'd0, 1'b1);
    #1;
    check("lit_mis_sw_we", mem_we, 4'b0000);
    tick();
    check("lit_mis_set", misaligned, 1);
    check("lit_mis_model", mMis, 1);
    applyStimulus(B_RD, 2'b11, 32'h10, 1'b0, 32'h0, 5'd4, 1'b1);
    tick();
    check("lit_mis_sticky", misaligned, 1);
    check("lit_mis_lw_read", read_data, 32'h8081F2F3);
    applyStimulus(B_RD | B_LH, 2'b11, 32'h21, 1'b0, 32'h0, 5'd5, 1'b1);
    tick();
    check("lit_mis_lh_wb", writeBack_bus_out, 2'b01);
    check("lit_mis_lh_model", mWb, 2'b01);

    applyStimulus(B_RD | B_LB, 2'b11, 32'h11, 1'b0, 32'h0, 5'd6, 1'b1);
    tick();
    check("lit_pre_rst_read", read_data, 32'hFFFFFFF2);
    reset = 1'b1;
    tick();
    reset = 1'b0;
    applyStimulus(9'h000, 2'b00, 32'h0, 1'b0, 32'h0, 5'd0, 1'b0);
    #1;
    check("lit_post_rst_wb", writeBack_bus_out, 2'b00);
    check("lit_post_rst_read", read_data, 32'h0);
    check("lit_post_rst_alu", alu_result_out, 32'h0);
    check("lit_post_rst_rd", rd_out, 0);
    check("lit_post_rst_mis", misaligned, 0);
    tick();
    applyStimulus(B_RD, 2'b11, 32'h10, 1'b0, 32'h0, 5'd1, 1'b1);
    tick();
    check("lit_recover_read", read_data, 32'h8081F2F3);
    check("lit_recover_mis", misaligned, 0);

    tick();
    checkEn = 1'b0;
    $display("== %0d vectors applied, %0d miscompares ==", nVectors, nMiss);
    $finish;
  end

endmodule
